// File: rtl/pipe_hazard_sequencer.sv
// Y86-64 five-stage pipeline control: hazard decode into stall/bubble controls plus a
// run/drain/halt sequencer. Optional hazard counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [3:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [3:0] S_AOK    = 4'h1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       halted_q, halted_d;
  logic [3:0] halt_stat_q, halt_stat_d;
  logic       lu, mp, rt, exc_m, exc_w;

  always_comb begin
    lu    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mp    = (E_icode == I_JXX) && !e_cnd;
    rt    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    exc_m = (m_stat != S_AOK);
    exc_w = (W_stat != S_AOK);
  end

  always_comb begin
    state_d     = state_q;
    halt_stat_d = halt_stat_q;
    F_stall     = 1'b1;
    D_stall     = 1'b0;
    D_bubble    = 1'b1;
    E_bubble    = 1'b1;
    M_bubble    = 1'b1;
    W_stall     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Load-use wins over ret: the ret stays parked in D while it is held, not bubbled.
        F_stall  = lu | rt;
        D_stall  = lu;
        D_bubble = mp | (!lu & rt);
        E_bubble = mp | lu;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
        if (exc_m || exc_w) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        W_stall  = exc_w;
        if (exc_w) begin
          halt_stat_d = W_stat;
          state_d     = ST_HALTED;
        end
      end
      default: begin
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        W_stall  = 1'b1;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      halted_q    <= 1'b0;
      halt_stat_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      halt_stat_q <= halt_stat_d;
    end
  end

  assign halted    = halted_q;
  assign halt_stat = halt_stat_q;
  assign dbg_state = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             in_run;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  always_comb begin
    in_run    = (state_q == ST_RUN);
    cyc_cnt_d = sat_inc(cyc_cnt_q, in_run);
    lu_cnt_d  = sat_inc(lu_cnt_q, in_run & lu);
    mp_cnt_d  = sat_inc(mp_cnt_q, in_run & mp);
    ret_cnt_d = sat_inc(ret_cnt_q, in_run & rt & !lu);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      lu_cnt_q  <= '0;
      mp_cnt_q  <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      lu_cnt_q  <= lu_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign lu_cnt  = lu_cnt_q;
  assign mp_cnt  = mp_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  assign cyc_cnt = '0;
  assign lu_cnt  = '0;
  assign mp_cnt  = '0;
  assign ret_cnt = '0;
`endif

endmodule
